// File: rtl/t04_mem_pkg.sv
// Shared types and default address map for the datapath memory arbiter.
package t04_mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned KEY_W  = 8;

  localparam logic [ADDR_W-1:0] DISP_BASE_DEF = 32'h0000_D000;
  localparam logic [ADDR_W-1:0] DISP_SIZE_DEF = 32'h0000_0100;
  localparam logic [ADDR_W-1:0] KEY_ADDR_DEF  = 32'h0000_E000;
  localparam int unsigned       TIMEOUT_DEF   = 64;

  typedef enum logic [2:0] {
    IDLE,
    RAM_REQ,
    RAM_WAIT,
    DISP_WAIT,
    KEY_WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_DISP,
    TGT_KEY
  } tgt_t;

  typedef enum logic {
    GNT_INSTR,
    GNT_DATA
  } gnt_t;

  // Request fields captured at grant time
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  sel;
    logic              write;
    tgt_t              target;
  } req_t;

endpackage

// File: rtl/t04_addr_decoder.sv
// Maps a data address onto the RAM, display window or keypad register.
module t04_addr_decoder
  import t04_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DISP_BASE = DISP_BASE_DEF,
  parameter logic [ADDR_W-1:0] DISP_SIZE = DISP_SIZE_DEF,
  parameter logic [ADDR_W-1:0] KEY_ADDR  = KEY_ADDR_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output tgt_t              target_c
);

  // One extra bit so a window touching the top of the map cannot wrap
  localparam logic [ADDR_W:0] DISP_END = {1'b0, DISP_BASE} + {1'b0, DISP_SIZE};

  // Keypad register takes priority over the display window
  always_comb begin
    target_c = TGT_RAM;
    if (addr == KEY_ADDR) begin
      target_c = TGT_KEY;
    end else if ((addr >= DISP_BASE) && ({1'b0, addr} < DISP_END)) begin
      target_c = TGT_DISP;
    end
  end

endmodule

// File: rtl/t04_mem_arbiter.sv
// Round-robin arbiter between instruction fetch and data access, driving
// the wishbone RAM port, display write port and keypad read.
module t04_mem_arbiter
  import t04_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DISP_BASE = DISP_BASE_DEF,
  parameter logic [ADDR_W-1:0] DISP_SIZE = DISP_SIZE_DEF,
  parameter logic [ADDR_W-1:0] KEY_ADDR  = KEY_ADDR_DEF,
  parameter int unsigned       TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [SEL_W-1:0]  d_sel,
  input  logic              busy,
  input  logic [DATA_W-1:0] wb_rdata,
  input  logic              display_ack,
  input  logic              key_en,
  input  logic [KEY_W-1:0]  key_data,
  output logic              wb_read,
  output logic              wb_write,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [SEL_W-1:0]  wb_sel,
  output logic              disp_wen,
  output logic [DATA_W-1:0] disp_data,
  output logic              i_ack,
  output logic              d_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

  state_t               state;
  gnt_t                 cur_grant;
  gnt_t                 last_grant;
  logic                 req_write;
  logic                 busy_seen;
  logic [TIMER_W-1:0]   timer;

  tgt_t                 d_target_c;
  logic                 d_pending_c;
  logic                 grant_instr_c;
  req_t                 next_req_c;
  logic                 complete_c;
  logic                 timeout_c;
  logic [DATA_W-1:0]    comp_data_c;

  t04_addr_decoder #(
    .DISP_BASE (DISP_BASE),
    .DISP_SIZE (DISP_SIZE),
    .KEY_ADDR  (KEY_ADDR)
  ) u_addr_decoder (
    .addr     (d_addr),
    .target_c (d_target_c)
  );

  // Arbitration: on a tie the requester not served last wins
  always_comb begin
    d_pending_c   = MemRead | MemWrite;
    grant_instr_c = i_req;
    if (i_req && d_pending_c) begin
      grant_instr_c = (last_grant == GNT_DATA);
    end
    next_req_c = '0;
    if (grant_instr_c) begin
      next_req_c.addr   = i_addr;
      next_req_c.sel    = {SEL_W{1'b1}};
      next_req_c.write  = 1'b0;
      next_req_c.target = TGT_RAM;
    end else begin
      next_req_c.addr   = d_addr;
      next_req_c.wdata  = d_wdata;
      next_req_c.sel    = d_sel;
      next_req_c.write  = MemWrite;
      next_req_c.target = d_target_c;
    end
  end

  // Completion detect for the wait states; a real response beats the timeout
  always_comb begin
    complete_c  = 1'b0;
    timeout_c   = 1'b0;
    comp_data_c = '0;
    case (state)
      RAM_WAIT: begin
        if (!busy && busy_seen) begin
          complete_c  = 1'b1;
          comp_data_c = wb_rdata;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          complete_c = 1'b1;
          timeout_c  = 1'b1;
        end
      end
      DISP_WAIT: begin
        if (!req_write || display_ack) begin
          complete_c = 1'b1;
        end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          complete_c = 1'b1;
          timeout_c  = 1'b1;
        end
      end
      KEY_WAIT: begin
        if (req_write) begin
          complete_c = 1'b1;
        end else if (key_en) begin
          complete_c  = 1'b1;
          comp_data_c = {{(DATA_W - KEY_W){1'b0}}, key_data};
        end
      end
      default: ;
    endcase
  end

  // Transaction sequencer with registered target strobes and ack pulses
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      cur_grant  <= GNT_INSTR;
      last_grant <= GNT_DATA;
      req_write  <= 1'b0;
      busy_seen  <= 1'b0;
      timer      <= '0;
      wb_read    <= 1'b0;
      wb_write   <= 1'b0;
      wb_adr     <= '0;
      wb_wdata   <= '0;
      wb_sel     <= '0;
      disp_wen   <= 1'b0;
      disp_data  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      wb_read  <= 1'b0;
      wb_write <= 1'b0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_pending_c) begin
            cur_grant <= grant_instr_c ? GNT_INSTR : GNT_DATA;
            req_write <= next_req_c.write;
            busy_seen <= 1'b0;
            timer     <= '0;
            case (next_req_c.target)
              TGT_RAM: begin
                state    <= RAM_REQ;
                wb_read  <= ~next_req_c.write;
                wb_write <= next_req_c.write;
                wb_adr   <= next_req_c.addr;
                wb_wdata <= next_req_c.wdata;
                wb_sel   <= next_req_c.sel;
              end
              TGT_DISP: begin
                state     <= DISP_WAIT;
                disp_wen  <= next_req_c.write;
                disp_data <= next_req_c.write ? next_req_c.wdata : '0;
              end
              default: state <= KEY_WAIT;
            endcase
          end
        end
        RAM_REQ: state <= RAM_WAIT;
        RAM_WAIT, DISP_WAIT, KEY_WAIT: begin
          if (complete_c) begin
            state     <= DONE;
            err       <= timeout_c;
            wb_adr    <= '0;
            wb_wdata  <= '0;
            wb_sel    <= '0;
            disp_wen  <= 1'b0;
            disp_data <= '0;
            if (cur_grant == GNT_INSTR) begin
              i_ack   <= 1'b1;
              i_rdata <= comp_data_c;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= comp_data_c;
            end
          end else begin
            if ((state == RAM_WAIT) && busy) busy_seen <= 1'b1;
            if (state != KEY_WAIT) timer <= timer + TIMER_W'(1);
          end
        end
        DONE: begin
          last_grant <= cur_grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t04_mem_arbiter.sv
// Directed plus randomized bench for t04_mem_arbiter with a transaction-level model.
module tb_t04_mem_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_req, MemRead, MemWrite, busy, display_ack, key_en;
  logic [31:0] i_addr, d_addr, d_wdata, wb_rdata;
  logic [3:0]  d_sel;
  logic [7:0]  key_data;
  logic        wb_read, wb_write, disp_wen, i_ack, d_ack, err;
  logic [31:0] wb_adr, wb_wdata, disp_data, i_rdata, d_rdata;
  logic [3:0]  wb_sel;
  logic [169:0] all_out;

  int n_vec = 0;
  int n_err = 0;

  // Model state: which side was served last, and last read data per port
  bit          m_last_data = 1'b1;
  logic [31:0] m_i = '0;
  logic [31:0] m_d = '0;

  // Responder profile for the next transaction
  int          p_lead, p_high, p_disp_at, p_key_at;
  logic [31:0] rd_base;
  bit          drop_req;

  always #5 clk = ~clk;

  assign all_out = {wb_read, wb_write, wb_adr, wb_wdata, wb_sel, disp_wen, disp_data,
                    i_ack, d_ack, i_rdata, d_rdata, err};

  t04_mem_arbiter dut (
    .clk(clk), .nrst(nrst), .i_req(i_req), .i_addr(i_addr),
    .MemRead(MemRead), .MemWrite(MemWrite), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_sel(d_sel), .busy(busy), .wb_rdata(wb_rdata), .display_ack(display_ack),
    .key_en(key_en), .key_data(key_data), .wb_read(wb_read), .wb_write(wb_write),
    .wb_adr(wb_adr), .wb_wdata(wb_wdata), .wb_sel(wb_sel), .disp_wen(disp_wen),
    .disp_data(disp_data), .i_ack(i_ack), .d_ack(d_ack), .i_rdata(i_rdata),
    .d_rdata(d_rdata), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 = RAM, 1 = display window, 2 = keypad
  function automatic int model_target(input logic [31:0] a);
    if (a == 32'h0000_E000) return 2;
    if (a >= 32'h0000_D000 && (a - 32'h0000_D000) < 32'h0000_0100) return 1;
    return 0;
  endfunction

  // Runs one transaction from an IDLE-cycle negedge; returns at the next IDLE negedge
  task automatic run_txn();
    bit g_instr, wr, exp_err, got_i, got_err, both;
    int tgt, exp_k, exp_wen, ack_k, rd_n, wr_n, wen_n, err_n, hold_bad, ddata_bad;
    logic [31:0] adr, wd, exp_data, got_data, other;
    logic [3:0] sel;

    g_instr = (i_req && (MemRead || MemWrite)) ? m_last_data : i_req;
    adr = g_instr ? i_addr : d_addr;
    wr  = !g_instr && MemWrite;
    wd  = d_wdata;
    sel = d_sel;
    tgt = g_instr ? 0 : model_target(d_addr);

    exp_err = 1'b0; exp_data = '0; exp_wen = 0;
    if (tgt == 0) begin
      if (p_high > 0 && p_lead + p_high < 63) begin
        exp_k = 3 + p_lead + p_high;
        exp_data = rd_base ^ 32'(exp_k - 1);
      end else begin
        exp_k = 66; exp_err = 1'b1;
      end
    end else if (tgt == 1) begin
      if (!wr) exp_k = 2;
      else if (p_disp_at < 63) begin exp_k = p_disp_at + 2; exp_wen = p_disp_at + 1; end
      else begin exp_k = 65; exp_wen = 64; exp_err = 1'b1; end
    end else begin
      if (wr) exp_k = 2;
      else begin exp_k = p_key_at + 2; exp_data = {24'h0, key_data}; end
    end

    busy = 1'b0; display_ack = 1'b0; key_en = 1'b0; wb_rdata = rd_base;
    ack_k = 0; rd_n = 0; wr_n = 0; wen_n = 0; err_n = 0; hold_bad = 0; ddata_bad = 0;
    got_i = 0; got_err = 0; both = 0; got_data = '0; other = '0;
    for (int k = 1; k <= 200 && ack_k == 0; k++) begin
      @(posedge clk); @(negedge clk);
      if (wb_read) rd_n++;
      if (wb_write) wr_n++;
      if (k == 1 && tgt == 0) begin
        chk("wb_adr_at_strobe", wb_adr, adr);
        if (!g_instr) chk("wb_sel_at_strobe", 32'(wb_sel), 32'(sel));
        if (wr) chk("wb_wdata_at_strobe", wb_wdata, wd);
      end
      if (disp_wen) begin
        wen_n++;
        if (disp_data !== wd) ddata_bad++;
      end
      if (i_ack || d_ack) begin
        ack_k = k; got_i = i_ack; both = i_ack && d_ack; got_err = err;
        got_data = i_ack ? i_rdata : d_rdata;
        other    = i_ack ? d_rdata : i_rdata;
      end else begin
        if (err) err_n++;
        if (tgt == 0 && wb_adr !== adr) hold_bad++;
      end
      if (k == 1) begin
        i_addr = $urandom & 32'h0000_0FFC; d_addr = $urandom & 32'h0000_0FFC;
        d_wdata = $urandom; d_sel = 4'($urandom);
      end
      if (k == 2 && drop_req) begin i_req = 0; MemRead = 0; MemWrite = 0; end
      busy = (tgt == 0) && (k >= 2) && (k - 2 >= p_lead) && (k - 2 < p_lead + p_high);
      display_ack = (tgt == 1) && (k - 1 == p_disp_at);
      key_en = (tgt == 2) && (k - 1 >= p_key_at);
      wb_rdata = rd_base ^ 32'(k);
    end
    if (ack_k == 0) chk("ack_within_budget", 32'(0), 32'(1));

    chk("ack_cycle", 32'(ack_k), 32'(exp_k));
    chk("ack_port_instr", 32'(got_i), 32'(g_instr));
    chk("ack_both_ports", 32'(both), 32'(0));
    chk("err_at_done", 32'(got_err), 32'(exp_err));
    chk("rdata", got_data, exp_data);
    chk("other_rdata_held", other, g_instr ? m_d : m_i);
    chk("wb_read_pulses", 32'(rd_n), 32'(tgt == 0 && !wr));
    chk("wb_write_pulses", 32'(wr_n), 32'(tgt == 0 && wr));
    chk("disp_wen_cycles", 32'(wen_n), 32'(exp_wen));
    chk("err_before_done", 32'(err_n), 32'(0));
    chk("wb_adr_held", 32'(hold_bad), 32'(0));
    chk("disp_data_held", 32'(ddata_bad), 32'(0));

    m_last_data = !g_instr;
    if (g_instr) m_i = exp_data; else m_d = exp_data;

    @(posedge clk); @(negedge clk);
    chk("ack_one_cycle", 32'({i_ack, d_ack, err}), 32'(0));
    chk("rdata_held_after", g_instr ? i_rdata : d_rdata, exp_data);
  endtask

  task automatic set_profile(input int lead, input int high, input int disp_at, input int key_at);
    p_lead = lead; p_high = high; p_disp_at = disp_at; p_key_at = key_at;
    rd_base = $urandom;
  endtask

  initial begin
    nrst = 1'b0; busy = 0; display_ack = 0; key_en = 0; key_data = 8'h00; wb_rdata = '0;
    i_addr = 32'h40; d_addr = 32'h80; d_wdata = '0; d_sel = 4'hF; drop_req = 0;
    i_req = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;

    // Reset state with both requesters already asserted
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", 32'(|all_out), 32'(0));
    nrst = 1'b1;

    // Held instruction + data requests: alternating service, instruction first
    for (int t = 0; t < 6; t++) begin
      set_profile(0, 1 + t % 3, 0, 0);
      run_txn();
    end

    // Fetch with busy 0,1,1,0
    i_req = 1; MemRead = 0; MemWrite = 0; i_addr = 32'h100;
    set_profile(1, 2, 0, 0);
    run_txn();

    // Display write acknowledged on its fifth enable cycle
    i_req = 0; MemWrite = 1; d_addr = 32'hD004; d_wdata = 32'hAB; d_sel = 4'h1;
    set_profile(0, 0, 4, 0);
    run_txn();

    // Keypad read with a long wait for a key
    MemWrite = 0; MemRead = 1; d_addr = 32'hE000; key_data = 8'h3C;
    set_profile(0, 0, 0, 100);
    run_txn();

    // RAM read with busy stuck high times out
    d_addr = 32'h0000_0400;
    set_profile(0, 1000, 0, 0);
    run_txn();

    // Display window edges and a display read
    MemRead = 1; d_addr = 32'hD0FF;
    set_profile(0, 0, 0, 0);
    run_txn();
    MemRead = 0; MemWrite = 1; d_addr = 32'hD100; d_wdata = 32'h1234_5678;
    set_profile(0, 3, 0, 0);
    run_txn();

    // Reset during RAM_WAIT aborts silently
    MemWrite = 0; i_req = 1; i_addr = 32'h300;
    busy = 0; display_ack = 0; key_en = 0;
    @(posedge clk); @(negedge clk);
    busy = 1;
    repeat (3) @(negedge clk);
    nrst = 1'b0; i_req = 0; busy = 0;
    #1;
    chk("reset_mid_outputs_zero", 32'(|all_out), 32'(0));
    @(negedge clk);
    nrst = 1'b1;
    m_last_data = 1'b1; m_i = '0; m_d = '0;
    repeat (3) begin
      @(negedge clk);
      chk("no_ack_after_abort", 32'({i_ack, d_ack, err, wb_read}), 32'(0));
    end
    i_req = 1; i_addr = 32'h304;
    set_profile(0, 1, 0, 0);
    run_txn();

    // Randomized mix of requesters, targets and responder timing
    for (int t = 0; t < 40; t++) begin
      int r, reg_sel;
      r = $urandom_range(0, 3);
      i_req    = (r != 1);
      MemRead  = (r != 0);
      MemWrite = (r == 3) || (r != 0 && $urandom_range(0, 1) == 1);
      i_addr   = $urandom;
      reg_sel  = $urandom_range(0, 3);
      case (reg_sel)
        0: d_addr = $urandom & 32'h0000_CFFC;
        1: d_addr = 32'h0000_D000 + 32'($urandom_range(0, 255));
        2: d_addr = 32'h0000_E000;
        default: d_addr = 32'h0000_CF00 + 32'($urandom_range(0, 767)) * 32'h10;
      endcase
      d_wdata  = $urandom;
      d_sel    = 4'($urandom);
      key_data = 8'($urandom);
      drop_req = ($urandom_range(0, 7) == 0);
      set_profile($urandom_range(0, 3), $urandom_range(0, 5),
                  ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 8),
                  $urandom_range(0, 8));
      run_txn();
      drop_req = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
